// File: rtl/prng_req_arbiter.sv
// prng_req_arbiter: round-robin sharing of one prng_lcg between N_REQ requesters.
// Define PRNG_RANGE_EN to enable per-requester rejection sampling against req_bound_i.
module prng_req_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DAT_W     = 32,
    parameter int TYP_W     = 2,
    parameter int GEN_WAIT  = 7,
    parameter int SEED_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 seed_vld_i,
    input  logic [DAT_W-1:0]     seed_dat_i,
    output logic                 seed_rdy_o,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ*15-1:0]  req_bound_i,
    output logic [N_REQ-1:0]     rnd_vld_o,
    output logic [14:0]          rnd_dat_o,
    output logic                 busy_o,
    output logic [TYP_W-1:0]     prng_typ_sel_o,
    output logic                 prng_t_sel_o,
    output logic [DAT_W-1:0]     prng_t_dat_o,
    input  logic [DAT_W-1:0]     prng_r_dat_i
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2((GEN_WAIT > SEED_WAIT ? GEN_WAIT : SEED_WAIT) + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED_ISSUE, S_SEED_WAIT, S_GEN_ISSUE, S_GEN_WAIT, S_DELIVER
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     rr_q, g_q, g_d;
    logic [CW-1:0]     cnt_q;
    logic              seed_rdy_q, prng_t_sel_q;
    logic [N_REQ-1:0]  rnd_vld_q;
    logic [14:0]       rnd_dat_q;
    logic [TYP_W-1:0]  prng_typ_sel_q;
    logic [DAT_W-1:0]  prng_t_dat_q;
    logic              reject;
    logic              unused_bits;

    // Descending scan so the requester closest after rr_q wins.
    always_comb begin
        g_d = rr_q;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req_i[(int'(rr_q) + k) % N_REQ]) g_d = PW'((int'(rr_q) + k) % N_REQ);
    end

`ifdef PRNG_RANGE_EN
    logic [14:0] bound;
    assign bound  = req_bound_i[int'(g_q)*15 +: 15];
    assign reject = (|bound) && (prng_r_dat_i[14:0] >= bound);
`else
    assign reject = 1'b0;
`endif

    assign unused_bits = ^{req_bound_i, prng_r_dat_i[DAT_W-1:15]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= S_IDLE;
            rr_q           <= '0;
            g_q            <= '0;
            cnt_q          <= '0;
            seed_rdy_q     <= 1'b0;
            rnd_vld_q      <= '0;
            rnd_dat_q      <= '0;
            prng_typ_sel_q <= '0;
            prng_t_sel_q   <= 1'b0;
            prng_t_dat_q   <= '0;
        end else begin
            seed_rdy_q     <= 1'b0;
            rnd_vld_q      <= '0;
            prng_t_sel_q   <= 1'b0;
            prng_typ_sel_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (seed_vld_i) begin
                        state_q        <= S_SEED_ISSUE;
                        seed_rdy_q     <= 1'b1;
                        prng_t_sel_q   <= 1'b1;
                        prng_t_dat_q   <= seed_dat_i;
                        prng_typ_sel_q <= TYP_W'(2);
                    end else if (|req_i) begin
                        state_q        <= S_GEN_ISSUE;
                        g_q            <= g_d;
                        prng_typ_sel_q <= TYP_W'(1);
                    end
                end
                S_SEED_ISSUE: state_q <= S_SEED_WAIT;
                S_SEED_WAIT: begin
                    if (cnt_q == CW'(SEED_WAIT - 1)) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                S_GEN_ISSUE: state_q <= S_GEN_WAIT;
                S_GEN_WAIT: begin
                    if (cnt_q == CW'(GEN_WAIT - 1)) begin
                        cnt_q <= '0;
                        if (reject) begin
                            state_q        <= S_GEN_ISSUE;
                            prng_typ_sel_q <= TYP_W'(1);
                        end else begin
                            state_q   <= S_DELIVER;
                            rnd_dat_q <= prng_r_dat_i[14:0];
                            rnd_vld_q <= N_REQ'(1) << g_q;
                        end
                    end else cnt_q <= cnt_q + 1'b1;
                end
                S_DELIVER: begin
                    state_q <= S_IDLE;
                    rr_q    <= (int'(g_q) == N_REQ - 1) ? '0 : g_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign seed_rdy_o     = seed_rdy_q;
    assign rnd_vld_o      = rnd_vld_q;
    assign rnd_dat_o      = rnd_dat_q;
    assign busy_o         = state_q != S_IDLE;
    assign prng_typ_sel_o = prng_typ_sel_q;
    assign prng_t_sel_o   = prng_t_sel_q;
    assign prng_t_dat_o   = prng_t_dat_q;
endmodule

// File: tb/tb_prng_req_arbiter.sv
// tb_prng_req_arbiter: directed + randomized bench for prng_req_arbiter with a behavioural prng_lcg stand-in.
// Expected words come from the LCG x'=x*1103515245+12345, word=x[30:16], four steps per generate command.
module tb_prng_req_arbiter;
`ifdef PRNG_RANGE_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic        clk = 1'b0, rst_b = 1'b0, seed_vld = 1'b0;
    logic [31:0] seed_dat = '0;
    logic        seed_rdy;
    logic [3:0]  req = '0;
    logic [59:0] req_bound = '0;
    logic [3:0]  rnd_vld;
    logic [14:0] rnd_dat;
    logic        busy;
    logic [1:0]  typ;
    logic        t_sel;
    logic [31:0] t_dat, r_dat;

    always #5 clk = ~clk;

    prng_req_arbiter dut (
        .clk(clk), .rst_b(rst_b), .seed_vld_i(seed_vld), .seed_dat_i(seed_dat),
        .seed_rdy_o(seed_rdy), .req_i(req), .req_bound_i(req_bound), .rnd_vld_o(rnd_vld),
        .rnd_dat_o(rnd_dat), .busy_o(busy), .prng_typ_sel_o(typ), .prng_t_sel_o(t_sel),
        .prng_t_dat_o(t_dat), .prng_r_dat_i(r_dat)
    );

    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * 32'd1103515245 + 32'd12345;
    endfunction

    // prng_lcg stand-in: seed load, or four LCG steps after a generate command
    logic [31:0] px;
    int          psteps;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            px     <= '0;
            psteps <= 0;
        end else if (typ == 2'd2 && t_sel) px <= t_dat;
        else if (typ == 2'd1) psteps <= 4;
        else if (psteps != 0) begin
            px     <= lcg(px);
            psteps <= psteps - 1;
        end
    end
    assign r_dat = {17'd0, px[30:16]};

    int          checks = 0, errors = 0;
    int          gens = 0, seeds = 0, rdys = 0, vlds = 0, gen_mark = 0;
    logic [1:0]  typ_log[$];
    logic [31:0] x_ref = '0;
    int          rr_ref = 0;
    logic [14:0] last_w = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (typ == 2'd1) gens++;
        if (typ == 2'd2) seeds++;
        if (typ != 2'd0) typ_log.push_back(typ);
        if (seed_rdy) rdys++;
        if (rnd_vld != 4'd0) vlds++;
    endtask

    task automatic wait_vld(input int lim, output int n, output logic [3:0] v);
        n = 0;
        v = '0;
        while (v == 4'd0 && n < lim) begin
            tick();
            n++;
            v = rnd_vld;
        end
        checks++;
        assert (v != 4'd0) else begin
            errors++;
            $error("FAIL vld_timeout observed=%0h expected=nonzero after %0d cycles", v, n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    function automatic int pick(input int rr, input logic [3:0] r);
        int g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && r[(rr + k) % 4]) g = (rr + k) % 4;
        return g;
    endfunction

    task automatic model_word(input logic [14:0] bound, output logic [14:0] w, output int att);
        att = 0;
        do begin
            for (int s = 0; s < 4; s++) x_ref = lcg(x_ref);
            att++;
            w = x_ref[30:16];
        end while (RANGE && bound != 15'd0 && w >= bound);
    endtask

    // One granted transaction: expected requester, word, latency and generate-command count
    task automatic serve(input logic [3:0] rs, input int exp_n, input string tag, output int g);
        logic [14:0] w;
        logic [3:0]  v;
        int          att, n;
        g = pick(rr_ref, rs);
        model_word(req_bound[g*15 +: 15], w, att);
        wait_vld(att * 8 + 12, n, v);
        chk({tag, "_vld"}, 32'(v), 32'(4'b0001 << g));
        chk({tag, "_dat"}, 32'(rnd_dat), 32'(w));
        if (exp_n >= 0) chk({tag, "_lat"}, n, exp_n + 8 * (att - 1));
        chk({tag, "_gens"}, gens - gen_mark, att);
        gen_mark = gens;
        rr_ref = (g + 1) % 4;
        last_w = w;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        x_ref = '0;
        rr_ref = 0;
        gen_mark = gens;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"}, 32'(seed_rdy), 32'd0);
        chk({tag, "_vld"}, 32'(rnd_vld), 32'd0);
        chk({tag, "_dat"}, 32'(rnd_dat), 32'd0);
        chk({tag, "_typ"}, 32'(typ), 32'd0);
        chk({tag, "_tsel"}, 32'(t_sel), 32'd0);
        chk({tag, "_tdat"}, t_dat, 32'd0);
    endtask

    initial begin
        int          g, vm, words;
        logic [3:0]  pend;
        logic [31:0] s;
        tick();
        tick();
        chk_zero("reset");
        rst_b = 1'b1;
        gen_mark = gens;

        // seed 0, then a single request from requester 0
        seed_vld = 1'b1;
        seed_dat = 32'd0;
        tick();
        chk("t1_rdy", 32'(seed_rdy), 32'd1);
        chk("t1_typ", 32'(typ), 32'd2);
        chk("t1_tsel", 32'(t_sel), 32'd1);
        chk("t1_tdat", t_dat, 32'd0);
        seed_vld = 1'b0;
        x_ref = 32'd0;
        wait_idle();
        req = 4'b0001;
        serve(4'b0001, 9, "t1", g);
        req = 4'b0000;
        chk("t1_rdy_once", rdys, 1);

        // seed and request in the same cycle: seed goes first
        wait_idle();
        typ_log.delete();
        s = $urandom;
        seed_vld = 1'b1;
        seed_dat = s;
        req = 4'b0010;
        tick();
        chk("t2_rdy", 32'(seed_rdy), 32'd1);
        seed_vld = 1'b0;
        x_ref = s;
        serve(4'b0010, 14, "t2", g);
        req = 4'b0000;
        chk("t2_log_n", typ_log.size(), 2);
        chk("t2_log0", 32'(typ_log[0]), 32'd2);
        chk("t2_log1", 32'(typ_log[1]), 32'd1);

        // round robin with all requesters held
        tick();
        do_reset();
        req = 4'b1111;
        serve(4'b1111, 9, "t3_0", g);
        for (int i = 1; i < 5; i++) serve(4'b1111, 10, $sformatf("t3_%0d", i), g);
        req = 4'b0000;
        repeat (3) tick();
        chk("t3_hold", 32'(rnd_dat), 32'(last_w));

        // reset during GEN_WAIT
        req = 4'b0100;
        repeat (3) tick();
        rst_b = 1'b0;
        #1;
        chk_zero("t4_rst");
        vm = vlds;
        req = 4'b0000;
        tick();
        rst_b = 1'b1;
        x_ref = '0;
        rr_ref = 0;
        gen_mark = gens;
        repeat (12) tick();
        chk("t4_no_vld", vlds, vm);
        req = 4'b0100;
        serve(4'b0100, 9, "t4", g);
        req = 4'b0000;

        // requester 2 drops its request mid-transaction
        tick();
        req = 4'b0100;
        repeat (3) tick();
        req = 4'b0001;
        serve(4'b0100, 6, "t6", g);
        serve(4'b0001, 10, "t6_a", g);
        serve(4'b0001, 10, "t6_b", g);
        req = 4'b0000;

        // bounded requester 0: rejection sampling when enabled, bound ignored otherwise
        tick();
        req_bound[14:0] = 15'd100;
        req = 4'b0001;
        words = RANGE ? 10 : 6;
        for (int i = 0; i < words; i++) begin
            serve(4'b0001, i == 0 ? 9 : 10, $sformatf("t5_%0d", i), g);
            if (RANGE) chk("t5_lt", 32'(rnd_dat < 15'd100), 32'd1);
        end
        req_bound[14:0] = 15'd0;
        serve(4'b0001, 10, "t5_b0", g);
        req = 4'b0000;

        // randomized pending sets; requesters hold until served
        tick();
        pend = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            pend = pend | 4'($urandom_range(1, 15));
            req = pend;
            serve(pend, -1, $sformatf("rnd_%0d", i), g);
            pend[g] = 1'b0;
            req = pend;
        end
        req = 4'b0000;
        repeat (12) tick();
        chk("end_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
